// File: rtl/regfile_wb_bank_pkg.sv
// Shared constants and types for the register-file write-back bank.
// The read ports import the same constants so slot geometry stays consistent.
package regfile_wb_bank_pkg;

  localparam int NREG   = 32;
  localparam int WIDTH  = 32;
  localparam int ADDR_W = 5;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  data;
  } stage_t;

endpackage

// File: rtl/dec_5to32.sv
// 5-to-32 one-hot decoder with enable; all outputs low when disabled.
module dec_5to32 (
  input  logic        en,
  input  logic [4:0]  addr,
  output logic [31:0] onehot
);

  assign onehot = en ? (32'd1 << addr) : 32'd0;

endmodule

// File: rtl/regfile_wb_bank_reg_en.sv
// WIDTH-bit storage register with load enable and async active-high reset.
module regfile_wb_bank_reg_en #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      q <= '0;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/regfile_wb_bank.sv
// 32x32 register storage with a one-entry write-back staging register whose
// contents are forwarded onto the flattened read bus while staged.
module regfile_wb_bank
  import regfile_wb_bank_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_W-1:0]     in_addr,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  freeze,
  output logic [NREG*WIDTH-1:0] r_bus,
  output logic                  wb_busy,
  output logic [31:0]           commit_count
);

  stage_t           stage_q;
  logic             accept;
  logic [NREG-1:0]  wr_en;
  logic             commit_inc;
  logic [31:0]      count_q;
  logic [WIDTH-1:0] regs [NREG-1:1];

  assign in_ready = ~freeze;
  assign accept   = in_valid & in_ready;

  // A new accept overwrites the stage on the same edge the old entry commits.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      stage_q <= '0;
    else if (accept)
      stage_q <= '{valid: 1'b1, addr: in_addr, data: in_data};
    else if (!freeze)
      stage_q.valid <= 1'b0;
  end

  dec_5to32 u_dec (
    .en     (stage_q.valid & ~freeze),
    .addr   (stage_q.addr),
    .onehot (wr_en)
  );

  // Register 0 decodes but has no storage, so it never counts as a commit.
  assign commit_inc = (|wr_en) & ~wr_en[0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      count_q <= '0;
    else if (commit_inc)
      count_q <= count_q + 32'd1;
  end

  assign commit_count = count_q;
  assign wb_busy      = stage_q.valid;

  for (genvar i = 1; i < NREG; i++) begin : g_regs
    regfile_wb_bank_reg_en #(.WIDTH(WIDTH)) u_reg (
      .clock (clock),
      .reset (reset),
      .en    (wr_en[i]),
      .d     (stage_q.data),
      .q     (regs[i])
    );
  end

  // Staged data wins over storage so readers always see the newest value.
  always_comb begin
    r_bus = '0;
    for (int i = 1; i < NREG; i++) begin
      if (stage_q.valid && stage_q.addr == ADDR_W'(i))
        r_bus[i*WIDTH +: WIDTH] = stage_q.data;
      else
        r_bus[i*WIDTH +: WIDTH] = regs[i];
    end
  end

endmodule
